// File: rtl/wbs_regfile.sv
// Wishbone classic slave exposing NUM_REGS byte-lane-writable registers.
// Each access waits WAIT_STATES cycles and then responds with ack (in range) or err.
module wbs_regfile #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 8,
  parameter int WAIT_STATES   = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  input  logic                           wb_we_i,
  input  logic [ADDRESS_WIDTH-1:0]       wb_adr_i,
  input  logic [DATA_WIDTH-1:0]          wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]        wb_sel_i,
  output logic                           wb_ack_o,
  output logic                           wb_err_o,
  output logic [DATA_WIDTH-1:0]          wb_dat_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_stb_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int L     = $clog2(LANES);
  localparam int I     = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I-1:0]          idx_q, idx_d;
  logic                  in_range_q, in_range_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic         req;
  logic         take;
  logic         adr_in_range;
  logic [I-1:0] adr_idx;
  logic         resp;

  assign req          = wb_cyc_i & wb_stb_i;
  assign adr_idx      = wb_adr_i[L +: I];
  // Low lane bits fall out of the shift, so sub-word addresses alias to their register.
  assign adr_in_range = ((wb_adr_i >> (L + I)) == '0);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    we_d       = we_q;
    regs_d     = regs_q;
    take       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            take = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          take  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request is captured only on the edge that enters RESP, never earlier.
    if (take) begin
      state_d    = RESP;
      idx_d      = adr_idx;
      in_range_d = adr_in_range;
      we_d       = wb_we_i;
      if (adr_in_range && wb_we_i) begin
        for (int b = 0; b < LANES; b++) begin
          if (wb_sel_i[b]) regs_d[adr_idx][8*b +: 8] = wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values; always_comb above uses blocking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      we_q       <= 1'b0;
      // NOTE: the register file is a small flop array read as regs_o, so it is cleared by reset like any other state.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      we_q       <= we_d;
      regs_q     <= regs_d;
    end
  end

  assign resp = (state_q == RESP);

  always_comb begin
    wb_ack_o = resp & in_range_q;
    wb_err_o = resp & ~in_range_q;
    wb_dat_o = '0;
    wr_stb_o = '0;
    regs_o   = '0;
    if (resp && in_range_q && !we_q) wb_dat_o = regs_q[idx_q];
    if (resp && in_range_q && we_q)  wr_stb_o[idx_q] = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: doc/wbs_regfile.md
WBS_REGFILE -- requirements
Module: wbs_regfile

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, byte-address width of wb_adr_i.
REQ-002 Parameter DATA_WIDTH, default 32, data width; SHALL be 8, 16, 32 or 64.
REQ-003 Parameter NUM_REGS, default 8, register count; SHALL be a power of 2, minimum 2.
REQ-004 Parameter WAIT_STATES, default 0, extra cycles inserted before each response, range 0-15.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 wb_cyc_i  in  1  bus cycle valid.
REQ-008 wb_stb_i  in  1  transfer strobe.
REQ-009 wb_we_i  in  1  1 = write, 0 = read.
REQ-010 wb_adr_i  in  ADDRESS_WIDTH  byte address.
REQ-011 wb_dat_i  in  DATA_WIDTH  write data.
REQ-012 wb_sel_i  in  DATA_WIDTH/8  byte lane enables.
REQ-013 wb_ack_o  out  1  normal termination.
REQ-014 wb_err_o  out  1  error termination.
REQ-015 wb_dat_o  out  DATA_WIDTH  read data, valid when wb_ack_o is 1.
REQ-016 regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-017 wr_stb_o  out  NUM_REGS  one-cycle pulse per register, bit k set in the cycle register k is updated.

Function
REQ-018 Lane bits L = log2(DATA_WIDTH/8); index bits I = log2(NUM_REGS); register index = wb_adr_i[L +: I].
REQ-019 An address is in range when wb_adr_i[ADDRESS_WIDTH-1 : L+I] is all zero; wb_adr_i[L-1:0] SHALL be ignored.
REQ-020 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-021 IDLE: on wb_cyc_i & wb_stb_i, the FSM SHALL go to WAIT when WAIT_STATES > 0 (loading the wait counter with WAIT_STATES), otherwise to RESP.
REQ-022 WAIT: the counter SHALL decrement each cycle; on reaching zero the FSM SHALL enter RESP on the next edge.
REQ-023 WAIT: if wb_cyc_i or wb_stb_i deasserts, the FSM SHALL return to IDLE with no register update and no response.
REQ-024 RESP lasts exactly one cycle: exactly one of wb_ack_o (in range) or wb_err_o (out of range) SHALL be 1, then the FSM SHALL return to IDLE.
REQ-025 Request-to-response latency SHALL be 1 + WAIT_STATES cycles.
REQ-026 Address, data, sel and we SHALL be sampled on the clock edge that enters RESP; the slave SHALL NOT latch them earlier.
REQ-027 An in-range write SHALL update only byte lanes with wb_sel_i set, on the edge entering RESP; wr_stb_o[index] SHALL be 1 during the RESP cycle.
REQ-028 A write with wb_sel_i all zero SHALL still be acked and SHALL pulse wr_stb_o, with register contents unchanged.
REQ-029 An in-range read SHALL drive the full register on wb_dat_o during RESP; wb_sel_i SHALL be ignored for reads.
REQ-030 Out-of-range accesses SHALL NOT modify any register or pulse wr_stb_o; wb_dat_o SHALL be zero during the err cycle.
REQ-031 Outside RESP, wb_ack_o, wb_err_o and wr_stb_o SHALL be 0 and wb_dat_o SHALL be zero.
REQ-032 Back-to-back: a strobe still held in the IDLE cycle following RESP SHALL start a new transfer, giving a minimum of 2 cycles per transfer.
REQ-033 regs_o SHALL reflect a write in the RESP cycle, the same cycle as wr_stb_o.

Reset
REQ-034 While rst_i is 1: FSM in IDLE, wait counter 0, all registers 0, and wb_ack_o, wb_err_o, wb_dat_o, wr_stb_o, regs_o all 0.
REQ-035 Reset asserted in WAIT or RESP SHALL abort the transfer immediately with no register update; after release, the FSM SHALL start in IDLE.

Verification
REQ-036 WAIT_STATES=0, write 0xDEADBEEF to adr 0x0004 with sel 0xF -> wb_ack_o 1 exactly one cycle after the strobe; wr_stb_o=0x02; regs_o reg1=0xDEADBEEF.
REQ-037 Then write 0x00001234 to adr 0x0004 with sel 0x3 -> reg1=0xDEAD1234; a read of adr 0x0004 returns 0xDEAD1234 with ack.
REQ-038 Access to adr 0x0020 (NUM_REGS=8, DW=32), read and write -> wb_err_o 1 for one cycle, wb_ack_o 0, no register changes, wr_stb_o 0.
REQ-039 WAIT_STATES=3, read adr 0x0008 -> ack on the 4th cycle after the strobe; dropping wb_stb_i after 2 cycles -> no ack and no err.
REQ-040 Strobe held continuously for 4 writes to adr 0x0000, 0x0004, 0x0008, 0x000C -> acks on alternate cycles with wr_stb_o 0x1, 0x2, 0x4, 0x8 in order.
REQ-041 rst_i pulsed during WAIT of a write -> target register stays 0, no ack, FSM in IDLE after release.
